selen_ifetch_responder: RTL

//  Responder for the core instruction-fetch port (i_req_val/i_req_addr -> i_req_ack/i_ack_rdata).

---
 rtl/selen_ifetch_responder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/selen_ifetch_responder.sv
// Instruction-fetch responder: maps each core fetch to one Wishbone classic read,
// with a one-entry last-fetch buffer and a timeout/error path that returns a safe word.
module selen_ifetch_responder #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_INSTR = 32'h0000_0013,
  parameter bit          BUF_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_val,
  input  logic [31:0] i_req_addr,
  output logic        i_req_ack,
  output logic [31:0] i_ack_rdata,
  input  logic        i_flush,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        fetch_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [29:0]   addr_q, addr_d;
  logic [29:0]   buf_addr_q, buf_addr_d;
  logic [31:0]   buf_data_q, buf_data_d;
  logic          buf_valid_q, buf_valid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ack_q, ack_d;
  logic          cyc_q, cyc_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic hit;
  logic req_match;
  logic unused_addr_bits;

  assign unused_addr_bits = ^i_req_addr[1:0];

  assign hit = BUF_EN && buf_valid_q && !i_flush && (i_req_addr[31:2] == buf_addr_q);
  // Ack only if the core is still asking for the address this response belongs to.
  assign req_match = i_req_val && (i_req_addr[31:2] == addr_q);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    buf_valid_d = buf_valid_q;
    rdata_d     = rdata_q;
    ack_d       = 1'b0;
    cyc_d       = cyc_q;
    err_d       = err_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (i_req_val) begin
          addr_d = i_req_addr[31:2];
          if (hit) begin
            rdata_d = buf_data_q;
            ack_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            cyc_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        if (cnt_q != TMAX) begin
          cnt_d = cnt_q + CW'(1);
        end
        // Error takes priority over a simultaneous ack.
        if (wb_err_i || (!wb_ack_i && (cnt_q == TMAX))) begin
          cyc_d       = 1'b0;
          rdata_d     = ERR_INSTR;
          err_d       = 1'b1;
          buf_valid_d = 1'b0;
          ack_d       = req_match;
          state_d     = S_RESP;
        end else if (wb_ack_i) begin
          cyc_d       = 1'b0;
          rdata_d     = wb_dat_i;
          buf_data_d  = wb_dat_i;
          buf_addr_d  = addr_q;
          buf_valid_d = BUF_EN;
          ack_d       = req_match;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
      end
    endcase

    if (i_flush) begin
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      buf_valid_q <= 1'b0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      cyc_q       <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      buf_valid_q <= buf_valid_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      cyc_q       <= cyc_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign i_req_ack   = ack_q;
  assign i_ack_rdata = rdata_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = 1'b0;
  assign wb_sel_o    = 4'hF;
  assign wb_adr_o    = {addr_q, 2'b00};
  assign fetch_err   = err_q;

endmodule
